// File: rtl/rv_pkg.sv
// Shared fetch-stage types: the existing PC-control bundle and the fetch sequencer state.
package rv_pkg;

    typedef struct packed {
        logic ready_Q100H;
        logic ready_Q101H;
        logic sel_next_pc_alu_out_Q102H;
    } t_if_ctrl;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } t_fetch_state;

    // Bubbles lost on a taken branch: the Q101H slot and the REDIRECT refetch.
    localparam int unsigned FETCH_BRANCH_PENALTY = 2;

endpackage

// File: rtl/rv_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module rv_sat_cnt #(
    parameter int unsigned W     = 4,
    parameter int unsigned LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != W'(LIMIT)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/rv_fetch_ctrl.sv
// Instruction-fetch sequencer: boot hold-off, PC control bundle, Q101H qualifiers,
// I_MEM grant-timeout monitor and stall performance counter.
module rv_fetch_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MAX_WAIT    = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_gnt,
    input  logic             stall_Q101H,
    input  logic             branch_taken_Q102H,
    output logic             imem_req,
    output t_if_ctrl         ctrl,
    output logic             flush_Q101H,
    output logic             valid_Q101H,
    output t_fetch_state     state,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    t_fetch_state      state_next;
    logic [BOOT_W-1:0] boot_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              valid_next;
    logic              advance;
    logic              wait_inc;
    logic              wait_hit;

    assign advance  = imem_gnt & ~stall_Q101H;
    assign wait_inc = imem_req & ~imem_gnt;
    // wait_inc and the clear (imem_gnt) are exclusive, so this is the edge wait_cnt hits MAX_WAIT.
    assign wait_hit = wait_inc & (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    rv_sat_cnt #(
        .W     (WAIT_W),
        .LIMIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (imem_gnt),
        .inc (wait_inc),
        .cnt (wait_cnt)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        state_next  = state;
        imem_req    = 1'b0;
        ctrl        = '0;
        flush_Q101H = 1'b0;
        valid_next  = valid_Q101H;
        unique case (state)
            BOOT: begin
                if (boot_cnt == '0) state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (branch_taken_Q102H) begin
                    ctrl.sel_next_pc_alu_out_Q102H = 1'b1;
                    ctrl.ready_Q100H               = 1'b1;
                    ctrl.ready_Q101H               = 1'b1;
                    flush_Q101H                    = 1'b1;
                    valid_next                     = 1'b0;
                    state_next                     = REDIRECT;
                end else if (advance) begin
                    ctrl.ready_Q100H = 1'b1;
                    ctrl.ready_Q101H = 1'b1;
                    valid_next       = 1'b1;
                end
            end
            REDIRECT: begin
                // Q101H still holds the wrong-path fetch; the Q102H slot is already killed.
                imem_req         = 1'b1;
                flush_Q101H      = 1'b1;
                ctrl.ready_Q100H = imem_gnt;
                ctrl.ready_Q101H = imem_gnt;
                valid_next       = imem_gnt;
                state_next       = FETCH;
            end
            default: state_next = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            boot_cnt    <= BOOT_W'(BOOT_CYCLES - 1);
            valid_Q101H <= 1'b0;
            err_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_next;
            valid_Q101H <= valid_next;
            if (state == BOOT && boot_cnt != '0) boot_cnt <= boot_cnt - BOOT_W'(1);
            if (wait_hit) err_timeout <= 1'b1;
            if (imem_req && !ctrl.ready_Q100H) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Self-checking bench for rv_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_rv_fetch_ctrl;
    import rv_pkg::*;

    localparam int unsigned BOOT_CYCLES = 2;
    localparam int unsigned MAX_WAIT    = 15;
    localparam int unsigned CNT_W       = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_gnt;
    logic             stall_Q101H;
    logic             branch_taken_Q102H;
    logic             imem_req;
    t_if_ctrl         ctrl;
    logic             flush_Q101H;
    logic             valid_Q101H;
    t_fetch_state     state;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rv_fetch_ctrl #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .MAX_WAIT    (MAX_WAIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .imem_gnt           (imem_gnt),
        .stall_Q101H        (stall_Q101H),
        .branch_taken_Q102H (branch_taken_Q102H),
        .imem_req           (imem_req),
        .ctrl               (ctrl),
        .flush_Q101H        (flush_Q101H),
        .valid_Q101H        (valid_Q101H),
        .state              (state),
        .err_timeout        (err_timeout),
        .stall_cnt          (stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic req;
        logic r0;
        logic r1;
        logic sel;
        logic flush;
    } exp_t;

    int unsigned      m_cyc      = 0;   // cycles since reset release, frozen once boot is over
    bit               m_redirect = 0;   // previous cycle took a branch out of normal fetch
    logic             m_valid    = 1'b0;
    int unsigned      m_wait     = 0;
    logic             m_err      = 1'b0;
    logic [CNT_W-1:0] m_stall    = '0;

    function automatic exp_t model_comb(input int unsigned cyc, input bit redir,
                                        input logic g, input logic s, input logic b);
        exp_t e = '0;
        if (cyc < BOOT_CYCLES) return e;
        e.req = 1'b1;
        if (redir) begin
            e.flush = 1'b1;
            e.r0    = g;
            e.r1    = g;
        end else if (b) begin
            e.sel   = 1'b1;
            e.r0    = 1'b1;
            e.r1    = 1'b1;
            e.flush = 1'b1;
        end else if (g && !s) begin
            e.r0 = 1'b1;
            e.r1 = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        exp_t        e;
        bit          booting;
        int unsigned nw;
        if (!rst) begin
            m_cyc      <= 0;
            m_redirect <= 0;
            m_valid    <= 1'b0;
            m_wait     <= 0;
            m_err      <= 1'b0;
            m_stall    <= '0;
        end else begin
            e       = model_comb(m_cyc, m_redirect, imem_gnt, stall_Q101H, branch_taken_Q102H);
            booting = (m_cyc < BOOT_CYCLES);
            if (booting) m_cyc <= m_cyc + 1;
            if (!booting) begin
                if (m_redirect)                     m_valid <= imem_gnt;
                else if (branch_taken_Q102H)        m_valid <= 1'b0;
                else if (imem_gnt && !stall_Q101H)  m_valid <= 1'b1;
            end
            if (e.req && !e.r0) m_stall <= m_stall + 1;
            nw = m_wait;
            if (imem_gnt) nw = 0;
            else if (e.req && nw < MAX_WAIT) nw = nw + 1;
            m_wait <= nw;
            if (nw == MAX_WAIT) m_err <= 1'b1;
            m_redirect <= !booting && !m_redirect && branch_taken_Q102H;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t         e;
        t_fetch_state es;
        e  = model_comb(m_cyc, m_redirect, imem_gnt, stall_Q101H, branch_taken_Q102H);
        es = (m_cyc < BOOT_CYCLES) ? BOOT : (m_redirect ? REDIRECT : FETCH);
        check("m_imem_req",  64'(imem_req),                       64'(e.req));
        check("m_ready100",  64'(ctrl.ready_Q100H),               64'(e.r0));
        check("m_ready101",  64'(ctrl.ready_Q101H),               64'(e.r1));
        check("m_sel",       64'(ctrl.sel_next_pc_alu_out_Q102H), 64'(e.sel));
        check("m_flush",     64'(flush_Q101H),                    64'(e.flush));
        check("m_valid",     64'(valid_Q101H),                    64'(m_valid));
        check("m_state",     64'(state),                          64'(es));
        check("m_err",       64'(err_timeout),                    64'(m_err));
        check("m_stall_cnt", 64'(stall_cnt),                      64'(m_stall));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic g, input logic s, input logic b);
        @(posedge clk);
        #1;
        imem_gnt           = g;
        stall_Q101H        = s;
        branch_taken_Q102H = b;
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic async_reset_check(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_state"}, 64'(state),       64'(BOOT));
        check({tag, "_req"},   64'(imem_req),    64'd0);
        check({tag, "_stall"}, 64'(stall_cnt),   64'd0);
        check({tag, "_err"},   64'(err_timeout), 64'd0);
        check({tag, "_valid"}, 64'(valid_Q101H), 64'd0);
    endtask

    initial begin
        rst                = 1'b1;
        imem_gnt           = 1'b1;
        stall_Q101H        = 1'b0;
        branch_taken_Q102H = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Boot window: cycles 0-1 idle, fetch from cycle 2, valid from cycle 3.
        release_reset();
        check("boot_req_c0",   64'(imem_req), 64'd0);
        check("boot_state_c0", 64'(state),    64'(BOOT));
        step(1, 0, 0);
        check("boot_req_c1",   64'(imem_req), 64'd0);
        step(1, 0, 0);
        check("boot_req_c2",   64'(imem_req),         64'd1);
        check("boot_rdy_c2",   64'(ctrl.ready_Q100H), 64'd1);
        check("boot_valid_c2", 64'(valid_Q101H),      64'd0);
        step(1, 0, 0);
        check("boot_valid_c3", 64'(valid_Q101H),      64'd1);

        // Straight-line fetch.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            check("line_rdy", 64'(ctrl.ready_Q100H),               64'd1);
            check("line_sel", 64'(ctrl.sel_next_pc_alu_out_Q102H), 64'd0);
        end
        check("line_stall_cnt", 64'(stall_cnt), 64'd0);

        // Backpressure for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0);
            check("bp_rdy100", 64'(ctrl.ready_Q100H), 64'd0);
            check("bp_rdy101", 64'(ctrl.ready_Q101H), 64'd0);
            check("bp_req",    64'(imem_req),         64'd1);
            check("bp_valid",  64'(valid_Q101H),      64'd1);
        end
        step(1, 0, 0);
        check("bp_stall_cnt", 64'(stall_cnt), 64'd3);

        // Branch during stall, then an ignored branch pulse in REDIRECT.
        step(1, 1, 1);
        check("br_sel",   64'(ctrl.sel_next_pc_alu_out_Q102H), 64'd1);
        check("br_rdy",   64'(ctrl.ready_Q100H),               64'd1);
        check("br_flush", 64'(flush_Q101H),                    64'd1);
        step(1, 0, 1);
        check("rd_state", 64'(state),                          64'(REDIRECT));
        check("rd_flush", 64'(flush_Q101H),                    64'd1);
        check("rd_sel",   64'(ctrl.sel_next_pc_alu_out_Q102H), 64'd0);
        check("rd_valid", 64'(valid_Q101H),                    64'd0);
        step(1, 0, 0);
        check("post_state", 64'(state),       64'(FETCH));
        check("post_valid", 64'(valid_Q101H), 64'd1);
        check("post_flush", 64'(flush_Q101H), 64'd0);

        // Grant timeout: err rises at the edge closing the 15th ungranted cycle.
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0);
            check("to_err_low", 64'(err_timeout), 64'd0);
        end
        step(1, 0, 0);
        check("to_err_set",   64'(err_timeout),      64'd1);
        check("to_advance",   64'(ctrl.ready_Q100H), 64'd1);
        check("to_stall_cnt", 64'(stall_cnt),        64'd18);
        repeat (3) step(1, 0, 0);
        check("to_err_sticky", 64'(err_timeout), 64'd1);

        // Asynchronous reset in REDIRECT with err set.
        step(1, 0, 1);
        step(1, 0, 0);
        check("ar1_pre_state", 64'(state), 64'(REDIRECT));
        async_reset_check("ar1");
        release_reset();

        // Asynchronous reset in REDIRECT with stall_cnt=5.
        step(1, 0, 0);
        repeat (5) step(1, 1, 0);
        step(1, 1, 1);
        step(0, 0, 0);
        check("ar2_pre_state", 64'(state),     64'(REDIRECT));
        check("ar2_pre_stall", 64'(stall_cnt), 64'd5);
        async_reset_check("ar2");
        release_reset();

        // Randomized traffic with grant droughts and occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom_range(999);
            if (r < 3) begin
                @(posedge clk);
                #1 rst = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
            end else if (r < 8) begin
                repeat (MAX_WAIT + 2) step(1'b0, 1'($urandom_range(1)), 1'b0);
            end else begin
                step(1'($urandom_range(99) < 75), 1'($urandom_range(99) < 25),
                     1'($urandom_range(99) < 10));
            end
        end
        repeat (2) step(1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv_fetch_ctrl.md
Name: rv_fetch_ctrl

Overview:
Sequencer for the instruction-fetch stage.
- Generates the t_if_ctrl bundle (PC enables, next-PC select) from the I_MEM handshake, decode backpressure and taken-branch redirect.
- Generates flush/valid qualifiers for Q101H.
- Holds fetch idle for a programmable boot window after reset.
- Monitors I_MEM for grant timeouts.
- Sits beside the fetch datapath; driven by I_MEM, decode (Q101H) and execute (Q102H).

Parameters:
BOOT_CYCLES, 2, cycles fetch stays idle after reset release (≥1)
MAX_WAIT, 15, consecutive ungranted request cycles before err_timeout sets (≥1)
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
imem_gnt  in  1  I_MEM accepts the current fetch request this cycle
stall_Q101H  in  1  decode cannot accept a new instruction
branch_taken_Q102H  in  1  Q102H instruction redirects; target is on alu_out_Q102H
imem_req  out  1  fetch request for pc_Q100H
ctrl  out  t_if_ctrl  ready_Q100H, ready_Q101H, sel_next_pc_alu_out_Q102H
flush_Q101H  out  1  instruction in Q101H is wrong-path; decode kills it
valid_Q101H  out  1  Q101H holds a live instruction
state  out  t_fetch_state  current FSM state (debug)
err_timeout  out  1  sticky I_MEM grant timeout
stall_cnt  out  CNT_W  count of cycles with imem_req=1 and ready_Q100H=0

Behaviour:
Reset (rst=0, asynchronous):
- state=BOOT, boot_cnt=BOOT_CYCLES-1, wait_cnt=0, err_timeout=0, stall_cnt=0, valid_Q101H=0.
- All combinational outputs are 0 while in BOOT.

FSM states: BOOT, FETCH, REDIRECT.

BOOT:
- imem_req=0; all ctrl fields 0; branch_taken_Q102H and stall_Q101H ignored.
- boot_cnt decrements each cycle; at boot_cnt==0, next state is FETCH.
- Total idle time is BOOT_CYCLES cycles after rst rises.

FETCH:
- imem_req=1.
- advance = imem_gnt & ~stall_Q101H.
- Priority 1, branch_taken_Q102H=1:
  - sel_next_pc_alu_out_Q102H=1, ready_Q100H=1, ready_Q101H=1, flush_Q101H=1.
  - Next state is REDIRECT.
  - Branch overrides stall and missing grant.
- Priority 2, advance=1:
  - ready_Q100H=ready_Q101H=1, sel=0 (PC+4).
  - valid_Q101H is 1 next cycle.
- Otherwise:
  - ready_Q100H=ready_Q101H=0; PC holds.
  - imem_req stays 1 for the same PC.
  - valid_Q101H holds its value.

REDIRECT (exactly one cycle):
- pc_Q101H holds the wrong-path PC, so flush_Q101H=1.
- imem_req=1 for the target.
- ready_Q100H=ready_Q101H=imem_gnt; sel=0.
- branch_taken_Q102H is ignored: its Q102H slot carries a killed instruction.
- valid_Q101H is 0 next cycle if imem_gnt=0, else 1.
- Next state is FETCH unconditionally; a missing grant is retried in FETCH.

valid_Q101H:
- Registered.
- Cleared on flush.
- Set on an advance without flush.

Grant timeout:
- wait_cnt increments on cycles with imem_req=1 and imem_gnt=0; it saturates at MAX_WAIT.
- wait_cnt clears on any cycle with imem_gnt=1.
- err_timeout sets when wait_cnt reaches MAX_WAIT and stays set until reset. Fetch keeps requesting.

stall_cnt:
- Increments (wrapping modulo 2^CNT_W) on any cycle with imem_req=1 and ready_Q100H=0.

Reset asserted mid-operation:
- Immediate return to BOOT with all registers at their reset values; no partial state survives.

Decomposition:
In rv_pkg:
- t_fetch_state enum (BOOT, FETCH, REDIRECT).
- The existing t_if_ctrl is reused unchanged.
- Constant FETCH_BRANCH_PENALTY=2.

Sub-module: rv_sat_cnt (parameterised width/limit saturating up-counter with clear), used for wait_cnt. boot_cnt and stall_cnt stay inline.

Test Plan:
1. Boot: release rst with BOOT_CYCLES=2 and imem_gnt=1 constant -> imem_req=0 for cycles 0-1; imem_req=1 and ready_Q100H=1 from cycle 2; valid_Q101H=1 from cycle 3.
2. Straight-line fetch: gnt=1, stall=0 for 10 cycles -> ready_Q100H=1 every cycle, sel=0, stall_cnt=0.
3. Backpressure: stall_Q101H=1 for 3 cycles -> ready_* = 0 for those 3 cycles, imem_req=1, stall_cnt=3, valid_Q101H held.
4. Branch during stall: stall_Q101H=1 and branch_taken_Q102H=1 in the same cycle -> sel=1, ready_*=1, flush_Q101H=1; next cycle state=REDIRECT and flush_Q101H=1; a branch pulse there is ignored; valid_Q101H returns to 1 one cycle later.
5. Timeout: MAX_WAIT=15, gnt=0 for 15 cycles -> err_timeout=1 on the 15th; then gnt=1 -> fetch advances and err_timeout stays 1 until rst.
6. Mid-run reset: assert rst=0 in REDIRECT with stall_cnt=5 -> state=BOOT, stall_cnt=0, err_timeout=0, imem_req=0 asynchronously, without waiting for a clock edge.
